// File: rtl/timer_bus_arbiter.sv
// Round-robin arbiter sharing the single Timer slave port among NUM_REQ requesters.
// Forwards one registered single-beat access at a time and routes the Timer irq to its owner.
module timer_bus_arbiter #(
  parameter int                NUM_REQ   = 4,
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 3,
  parameter logic [ADDR_W-1:0] CTRL_ADDR = '0,
  parameter int                TIMEOUT   = 64
) (
  input  logic                        clk,
  input  logic                        rest,
  input  logic [NUM_REQ-1:0]          m_req,
  output logic [NUM_REQ-1:0]          m_gnt,
  input  logic [NUM_REQ-1:0]          m_as,
  input  logic [NUM_REQ-1:0]          m_rw,
  input  logic [NUM_REQ*ADDR_W-1:0]   m_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   m_wr_data,
  output logic [NUM_REQ-1:0]          m_rdy,
  output logic [DATA_W-1:0]           m_rd_data,
  output logic                        m_err,
  output logic [NUM_REQ-1:0]          m_irq,
  output logic                        Timer_cs,
  output logic                        Timer_as,
  output logic                        Timer_rw,
  output logic [ADDR_W-1:0]           Timer_addr,
  output logic [DATA_W-1:0]           Timer_wr_data,
  input  logic                        Timer_rdy,
  input  logic [DATA_W-1:0]           Timer_rd_data,
  input  logic                        Timer_irq
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, GRANTED, WAIT_RDY} state_e;

  state_e              state_q;
  logic [NUM_REQ-1:0]  gnt_q;
  logic [IDX_W-1:0]    owner_q;
  logic [IDX_W-1:0]    rr_ptr_q;
  logic [NUM_REQ-1:0]  rdy_q;
  logic [DATA_W-1:0]   rd_data_q;
  logic                err_q;
  logic                cs_q;
  logic                tas_q;
  logic                trw_q;
  logic [ADDR_W-1:0]   taddr_q;
  logic [DATA_W-1:0]   twdata_q;
  logic [CNT_W-1:0]    wait_cnt_q;
  logic [IDX_W-1:0]    irq_owner_q;
  logic                irq_valid_q;

  logic                pick_valid_d;
  logic [IDX_W-1:0]    pick_idx_d;
  logic [IDX_W-1:0]    rr_ptr_d;
  logic                own_as;
  logic                own_req;
  logic                own_rw;
  logic [ADDR_W-1:0]   own_addr;
  logic [DATA_W-1:0]   own_wdata;

  // NOTE: every variable gets a default before the loop, otherwise the
  // no-request path leaves it unassigned and a latch is inferred.
  // Scanning downward lets the last hit be the first requester at or above rr_ptr.
  always_comb begin
    pick_valid_d = 1'b0;
    pick_idx_d   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (m_req[IDX_W'((int'(rr_ptr_q) + i) % NUM_REQ)]) begin
        pick_valid_d = 1'b1;
        pick_idx_d   = IDX_W'((int'(rr_ptr_q) + i) % NUM_REQ);
      end
    end
  end

  assign rr_ptr_d  = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
  assign own_as    = m_as[owner_q];
  assign own_req   = m_req[owner_q];
  assign own_rw    = m_rw[owner_q];
  assign own_addr  = m_addr[int'(owner_q) * ADDR_W +: ADDR_W];
  assign own_wdata = m_wr_data[int'(owner_q) * DATA_W +: DATA_W];

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      rdy_q       <= '0;
      rd_data_q   <= '0;
      err_q       <= 1'b0;
      cs_q        <= 1'b0;
      tas_q       <= 1'b0;
      trw_q       <= 1'b1;
      taddr_q     <= '0;
      twdata_q    <= '0;
      wait_cnt_q  <= '0;
      irq_owner_q <= '0;
      irq_valid_q <= 1'b0;
    end else begin
      tas_q <= 1'b0;
      rdy_q <= '0;
      case (state_q)
        IDLE: begin
          if (pick_valid_d) begin
            gnt_q   <= NUM_REQ'(1) << pick_idx_d;
            owner_q <= pick_idx_d;
            cs_q    <= 1'b1;
            state_q <= GRANTED;
          end
        end
        GRANTED: begin
          if (own_as) begin
            trw_q      <= own_rw;
            taddr_q    <= own_addr;
            twdata_q   <= own_wdata;
            tas_q      <= 1'b1;
            wait_cnt_q <= '0;
            state_q    <= WAIT_RDY;
          end else if (!own_req) begin
            gnt_q    <= '0;
            cs_q     <= 1'b0;
            rr_ptr_q <= rr_ptr_d;
            state_q  <= IDLE;
          end
        end
        WAIT_RDY: begin
          // A ready arriving on the timeout cycle still wins as a normal completion.
          if (Timer_rdy) begin
            rd_data_q <= trw_q ? Timer_rd_data : '0;
            err_q     <= 1'b0;
            rdy_q     <= gnt_q;
            state_q   <= GRANTED;
            if (!trw_q && (taddr_q == CTRL_ADDR)) begin
              irq_owner_q <= owner_q;
              irq_valid_q <= 1'b1;
            end
          end else if (wait_cnt_q == CNT_W'(TIMEOUT - 1)) begin
            rd_data_q <= '0;
            err_q     <= 1'b1;
            rdy_q     <= gnt_q;
            state_q   <= GRANTED;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m_gnt         = gnt_q;
  assign m_rdy         = rdy_q;
  assign m_rd_data     = rd_data_q;
  assign m_err         = err_q;
  assign Timer_cs      = cs_q;
  assign Timer_as      = tas_q;
  assign Timer_rw      = trw_q;
  assign Timer_addr    = taddr_q;
  assign Timer_wr_data = twdata_q;
  assign m_irq         = (Timer_irq && irq_valid_q) ? (NUM_REQ'(1) << irq_owner_q) : '0;

endmodule
